// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode encoding, FSM states and the flag bundle.
package alu_pkg;

    localparam int unsigned OPCODE_W = 8;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD       = 8'd0,
        OP_SUB       = 8'd1,
        OP_MUL       = 8'd2,
        OP_EQ        = 8'd3,
        OP_GT        = 8'd4,
        OP_GT_SIGNED = 8'd5,
        OP_ADDI      = 8'd9,
        OP_SUBI      = 8'd10
    } alu_op_t;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } alu_state_t;

    typedef struct packed {
        logic overflow;
        logic carry;
        logic zero;
        logic sign;
        logic parity;
        logic illegal_op;
    } alu_flags_t;

    // An empty result register reads as zero, so only the zero flag is set.
    localparam alu_flags_t FLAGS_RESET = '{overflow: 1'b0, carry: 1'b0, zero: 1'b1,
                                           sign: 1'b0, parity: 1'b0, illegal_op: 1'b0};

endpackage

// File: rtl/alu_pipe_if.sv
// Operation/result handshake bundle between the decoder, alu_pipe and writeback.
interface alu_pipe_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
);
    logic                enable_in;
    logic                in_valid_in;
    logic                in_ready_out;
    logic [OPCODE_W-1:0] opcode_in;
    logic [WIDTH-1:0]    alu_input1;
    logic [WIDTH-1:0]    alu_input2;
    logic                out_valid_out;
    logic                out_ready_in;
    logic [WIDTH-1:0]    alu_output;
    logic                overflow_flag;
    logic                carry_flag;
    logic                zero_flag;
    logic                sign_flag;
    logic                parity_flag;
    logic                illegal_op_flag;

    modport master (
        output enable_in, in_valid_in, opcode_in, alu_input1, alu_input2, out_ready_in,
        input  in_ready_out, out_valid_out, alu_output, overflow_flag, carry_flag,
               zero_flag, sign_flag, parity_flag, illegal_op_flag
    );

    modport slave (
        input  enable_in, in_valid_in, opcode_in, alu_input1, alu_input2, out_ready_in,
        output in_ready_out, out_valid_out, alu_output, overflow_flag, carry_flag,
               zero_flag, sign_flag, parity_flag, illegal_op_flag
    );
endinterface

// File: rtl/alu_iter_mul.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per step.
// product_c is the product after the current step, valid as the final result when done_c is high.
module alu_iter_mul #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned STEPS = WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 step,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done_c,
    output logic [2*WIDTH-1:0]   product_c
);
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH:0]     partial_c;

    // Upper half accumulates the multiplicand; lower half shifts the multiplier out LSB first.
    always_comb begin
        partial_c = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? mcand_q : WIDTH'(0))};
        product_c = {partial_c, prod_q[WIDTH-1:1]};
        done_c    = step && (cnt_q == CNT_W'(STEPS - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else if (start) begin
            mcand_q <= a;
            prod_q  <= {WIDTH'(0), b};
            cnt_q   <= '0;
        end else if (step) begin
            prod_q  <= product_c;
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready on both sides and an iterative MUL.
// Build option ALU_PIPE_SATURATE_EN: signed-overflowing ADD/SUB clamp instead of wrapping.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned MUL_CYCLES = WIDTH
) (
    input  logic       clock_in,
    input  logic       reset_in,
    alu_pipe_if.slave  bus
);
    localparam int unsigned MSB = WIDTH - 1;

    alu_state_t         state;
    logic               out_valid_q;
    logic [WIDTH-1:0]   result_q;
    alu_flags_t         flags_q;

    logic [WIDTH-1:0]   op_res_c;
    alu_flags_t         op_flags_c;
    logic [WIDTH-1:0]   mul_res_c;
    alu_flags_t         mul_flags_c;
    logic [WIDTH:0]     ext_add_c;
    logic [WIDTH:0]     ext_sub_c;
    logic [2*WIDTH-1:0] product_c;
    logic               accept_c;
    logic               is_mul_c;
    logic               mul_start_c;
    logic               mul_step_c;
    logic               mul_done_c;

    assign bus.in_ready_out = bus.enable_in && (state == ST_IDLE) &&
                              (!out_valid_q || bus.out_ready_in);
    assign accept_c    = bus.in_valid_in && bus.in_ready_out;
    assign is_mul_c    = (bus.opcode_in == OP_MUL);
    assign mul_start_c = accept_c && is_mul_c;
    assign mul_step_c  = (state == ST_MUL_BUSY) && bus.enable_in;

    alu_iter_mul #(
        .WIDTH (WIDTH),
        .STEPS (MUL_CYCLES)
    ) u_mul (
        .clk       (clock_in),
        .rst_n     (reset_in),
        .start     (mul_start_c),
        .step      (mul_step_c),
        .a         (bus.alu_input1),
        .b         (bus.alu_input2),
        .done_c    (mul_done_c),
        .product_c (product_c)
    );

    // Single-cycle ops, evaluated on the operands presented at the accept edge.
    always_comb begin
        op_res_c   = '0;
        op_flags_c = '0;
        ext_add_c  = {1'b0, bus.alu_input1} + {1'b0, bus.alu_input2};
        ext_sub_c  = {1'b0, bus.alu_input1} - {1'b0, bus.alu_input2};
        case (alu_op_t'(bus.opcode_in))
            OP_ADD, OP_ADDI: begin
                op_res_c            = ext_add_c[WIDTH-1:0];
                op_flags_c.carry    = ext_add_c[WIDTH];
                op_flags_c.overflow = (bus.alu_input1[MSB] == bus.alu_input2[MSB]) &&
                                      (ext_add_c[MSB] != bus.alu_input1[MSB]);
            end
            OP_SUB, OP_SUBI: begin
                op_res_c            = ext_sub_c[WIDTH-1:0];
                op_flags_c.carry    = ext_sub_c[WIDTH];
                op_flags_c.overflow = (bus.alu_input1[MSB] != bus.alu_input2[MSB]) &&
                                      (ext_sub_c[MSB] != bus.alu_input1[MSB]);
            end
            OP_EQ:        op_res_c = WIDTH'(bus.alu_input1 == bus.alu_input2);
            OP_GT:        op_res_c = WIDTH'(bus.alu_input1 > bus.alu_input2);
            OP_GT_SIGNED: op_res_c = WIDTH'($signed(bus.alu_input1) > $signed(bus.alu_input2));
            OP_MUL: begin
            end
            default:      op_flags_c.illegal_op = 1'b1;
        endcase
`ifdef ALU_PIPE_SATURATE_EN
        // Overflow only occurs toward the side of operand A's sign.
        if (op_flags_c.overflow) begin
            op_res_c = bus.alu_input1[MSB] ? {1'b1, {(WIDTH-1){1'b0}}}
                                           : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        op_flags_c.zero   = (op_res_c == '0);
        op_flags_c.sign   = op_res_c[MSB];
        op_flags_c.parity = ^op_res_c;
    end

    always_comb begin
        mul_res_c            = product_c[WIDTH-1:0];
        mul_flags_c          = '0;
        mul_flags_c.overflow = |product_c[2*WIDTH-1:WIDTH];
        mul_flags_c.carry    = |product_c[2*WIDTH-1:WIDTH];
        mul_flags_c.zero     = (mul_res_c == '0);
        mul_flags_c.sign     = mul_res_c[MSB];
        mul_flags_c.parity   = ^mul_res_c;
    end

    // Control FSM and result register; a consume and a new load may share an edge.
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= FLAGS_RESET;
        end else begin
            if (out_valid_q && bus.out_ready_in) begin
                out_valid_q <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (accept_c) begin
                        if (is_mul_c) begin
                            state <= ST_MUL_BUSY;
                        end else begin
                            result_q    <= op_res_c;
                            flags_q     <= op_flags_c;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ST_MUL_BUSY: begin
                    if (mul_done_c) begin
                        result_q    <= mul_res_c;
                        flags_q     <= mul_flags_c;
                        out_valid_q <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.out_valid_out   = out_valid_q;
    assign bus.alu_output      = result_q;
    assign bus.overflow_flag   = flags_q.overflow;
    assign bus.carry_flag      = flags_q.carry;
    assign bus.zero_flag       = flags_q.zero;
    assign bus.sign_flag       = flags_q.sign;
    assign bus.parity_flag     = flags_q.parity;
    assign bus.illegal_op_flag = flags_q.illegal_op;
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=8): directed vectors with hand-computed results.
module tb_alu_pipe;
    typedef struct packed {
        logic [7:0] res;
        logic [5:0] flg;   // {overflow, carry, zero, sign, parity, illegal_op}
    } exp_t;

`ifdef ALU_PIPE_SATURATE_EN
    localparam logic [7:0] ADD_OV_RES = 8'h7F;
    localparam logic [5:0] ADD_OV_FLG = 6'b100010;
    localparam logic [7:0] SUB_OV_RES = 8'h80;
    localparam logic [5:0] SUB_OV_FLG = 6'b100110;
`else
    localparam logic [7:0] ADD_OV_RES = 8'h80;
    localparam logic [5:0] ADD_OV_FLG = 6'b100110;
    localparam logic [7:0] SUB_OV_RES = 8'h7F;
    localparam logic [5:0] SUB_OV_FLG = 6'b100010;
`endif

    logic clock_in;
    logic reset_in;
    int   cyc;
    int   n_checks;
    int   n_pass;
    exp_t sb[$];
    exp_t mon_e;

    alu_pipe_if #(.WIDTH(8)) bus ();

    alu_pipe #(.WIDTH(8), .MUL_CYCLES(8)) dut (
        .clock_in (clock_in),
        .reset_in (reset_in),
        .bus      (bus)
    );

    initial begin
        clock_in = 1'b0;
        forever #5 clock_in = ~clock_in;
    end

    always @(posedge clock_in) cyc++;

    function automatic logic [5:0] get_flags();
        return {bus.overflow_flag, bus.carry_flag, bus.zero_flag,
                bus.sign_flag, bus.parity_flag, bus.illegal_op_flag};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, req, $time);
    endtask

    // Consumed results are popped at the mid-cycle point before the consuming edge.
    always @(negedge clock_in) begin
        if (reset_in && bus.out_valid_out && bus.out_ready_in) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got %0h required no output", bus.alu_output);
            end else begin
                mon_e = sb.pop_front();
                check("result{res,flags}", {bus.alu_output, get_flags()}, {mon_e.res, mon_e.flg});
            end
        end
    end

    // Entered and left 1 time unit after a rising edge; acc is the cycle index of the accept.
    task automatic issue(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eres, input logic [5:0] eflg, output int acc);
        exp_t e;
        bus.opcode_in   = op;
        bus.alu_input1  = a;
        bus.alu_input2  = b;
        bus.in_valid_in = 1'b1;
        acc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock_in);
            if (bus.in_ready_out) begin
                e.res = eres;
                e.flg = eflg;
                sb.push_back(e);
                acc = cyc;
                break;
            end
            @(posedge clock_in); #1;
        end
        if (acc < 0) begin
            n_checks++;
            $display("FAIL issue_timeout op=%0h: accepted=0 required=1", op);
            bus.in_valid_in = 1'b0;
        end else begin
            @(posedge clock_in); #1;
            bus.in_valid_in = 1'b0;
        end
    endtask

    // Cycles from the accept edge until out_valid_out is seen; optional 2-cycle enable drop.
    task automatic wait_out(input bit drop_en, output int lat, output bit rdy_seen);
        lat = 1;
        rdy_seen = 1'b0;
        while (!bus.out_valid_out && lat < 60) begin
            if (bus.in_ready_out) rdy_seen = 1'b1;
            if (drop_en && lat == 3) bus.enable_in = 1'b0;
            if (drop_en && lat == 5) bus.enable_in = 1'b1;
            @(posedge clock_in); #1;
            lat++;
        end
        bus.enable_in = 1'b1;
        if (!bus.out_valid_out) begin
            n_checks++;
            $display("FAIL wait_out_timeout: out_valid_out=0 required 1 within 60 cycles");
        end
    endtask

    task automatic drain();
        repeat (2) begin
            @(posedge clock_in); #1;
        end
    endtask

    initial begin
        int  acc, acc2, acc3, acc4, lat;
        bit  rdy, seen;
        reset_in         = 1'b0;
        bus.enable_in    = 1'b1;
        bus.in_valid_in  = 1'b0;
        bus.opcode_in    = 8'h00;
        bus.alu_input1   = 8'h00;
        bus.alu_input2   = 8'h00;
        bus.out_ready_in = 1'b1;
        repeat (3) @(posedge clock_in);
        #1;
        check("reset_out_valid", 32'(bus.out_valid_out), 0);
        check("reset_alu_output", 32'(bus.alu_output), 0);
        check("reset_flags", 32'(get_flags()), 32'b001000);
        reset_in = 1'b1;
        @(posedge clock_in); #1;

        // Reset while a result is held under backpressure.
        bus.out_ready_in = 1'b0;
        issue(8'd0, 8'h33, 8'h11, 8'h44, 6'b000000, acc);
        check("held_before_reset", 32'(bus.out_valid_out), 1);
        #2 reset_in = 1'b0;
        #1;
        sb.delete();
        check("midreset_out_valid", 32'(bus.out_valid_out), 0);
        check("midreset_alu_output", 32'(bus.alu_output), 0);
        check("midreset_flags", 32'(get_flags()), 32'b001000);
        @(posedge clock_in); #1;
        reset_in = 1'b1;
        bus.out_ready_in = 1'b1;
        @(posedge clock_in); #1;

        issue(8'd0, 8'h7F, 8'h01, ADD_OV_RES, ADD_OV_FLG, acc);
        wait_out(1'b0, lat, rdy);
        check("add_latency", 32'(lat), 1);
        issue(8'd0,  8'hFF, 8'h01, 8'h00, 6'b011000, acc);
        issue(8'd1,  8'h00, 8'h01, 8'hFF, 6'b010100, acc);
        issue(8'd10, 8'h80, 8'h01, SUB_OV_RES, SUB_OV_FLG, acc);
        issue(8'd9,  8'h05, 8'h03, 8'h08, 6'b000010, acc);
        issue(8'd4,  8'h80, 8'h01, 8'h01, 6'b000010, acc);
        issue(8'd5,  8'h80, 8'h01, 8'h00, 6'b001000, acc);
        issue(8'd3,  8'h5A, 8'h5A, 8'h01, 6'b000010, acc);
        issue(8'd7,  8'h12, 8'h34, 8'h00, 6'b001001, acc);

        // MUL with a stray request held valid while busy; it must not be taken.
        issue(8'd2, 8'h10, 8'h10, 8'h00, 6'b111000, acc);
        bus.opcode_in   = 8'd0;
        bus.alu_input1  = 8'h01;
        bus.alu_input2  = 8'h01;
        bus.in_valid_in = 1'b1;
        wait_out(1'b0, lat, rdy);
        bus.in_valid_in = 1'b0;
        check("mul_latency", 32'(lat), 9);
        check("mul_busy_ready", 32'(rdy), 0);
        drain();
        issue(8'd2, 8'h0C, 8'h0B, 8'h84, 6'b000100, acc);
        wait_out(1'b0, lat, rdy);
        check("mul2_latency", 32'(lat), 9);
        drain();
        issue(8'd2, 8'h0D, 8'h0D, 8'hA9, 6'b000100, acc);
        wait_out(1'b1, lat, rdy);
        check("mul_stall_latency", 32'(lat), 11);
        drain();

        // Backpressure: first result held while the second waits, then full rate.
        bus.out_ready_in = 1'b0;
        issue(8'd0, 8'h01, 8'h01, 8'h02, 6'b000010, acc);
        fork
            issue(8'd0, 8'h02, 8'h02, 8'h04, 6'b000010, acc2);
            begin
                repeat (3) begin
                    @(negedge clock_in);
                    check("bp_hold_output", 32'(bus.alu_output), 32'h02);
                    check("bp_in_ready", 32'(bus.in_ready_out), 0);
                end
                @(posedge clock_in); #2;
                bus.out_ready_in = 1'b1;
            end
        join
        issue(8'd0, 8'h03, 8'h03, 8'h06, 6'b000000, acc3);
        issue(8'd0, 8'h10, 8'h20, 8'h30, 6'b000000, acc4);
        check("throughput_2_3", 32'(acc3 - acc2), 1);
        check("throughput_3_4", 32'(acc4 - acc3), 1);
        drain();

        // Reset in the middle of a MUL: no result may appear afterwards.
        issue(8'd2, 8'h03, 8'h03, 8'h09, 6'b000000, acc);
        repeat (3) begin
            @(posedge clock_in); #1;
        end
        reset_in = 1'b0;
        #1;
        sb.delete();
        check("mulabort_out_valid", 32'(bus.out_valid_out), 0);
        @(posedge clock_in); #1;
        reset_in = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(negedge clock_in);
            if (bus.out_valid_out) seen = 1'b1;
        end
        check("mulabort_no_output", 32'(seen), 0);

        issue(8'd1, 8'h05, 8'h03, 8'h02, 6'b000010, acc);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clock_in);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end
endmodule
